// File: rtl/microprogram_sequencer.sv
// Microprogram sequencer: pc, condition select, return-address stack and optional loop counter.
// Define USEQ_LOOP_EN to build the loop counter and the LDCNT/LOOP ops (otherwise they act as CONT).
module microprogram_sequencer #(
  parameter int ADDR_W      = 7,
  parameter int CTRL_W      = 17,
  parameter int NUM_COND    = 4,
  parameter int STACK_DEPTH = 4,
  localparam int COND_SEL_W = (NUM_COND > 1) ? $clog2(NUM_COND) : 1,
  localparam int LVL_W      = $clog2(STACK_DEPTH + 1),
  localparam int UWORD_W    = 3 + COND_SEL_W + 1 + CTRL_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                hold,
  input  logic [NUM_COND-1:0] cond,
  input  logic [ADDR_W-1:0]   map_addr,
  input  logic [UWORD_W-1:0]  uword,
  output logic [ADDR_W-1:0]   uaddr,
  output logic [CTRL_W-1:0]   control_bus,
  output logic [LVL_W-1:0]    stack_level,
  output logic                stack_err
);

  typedef enum logic [2:0] {
    OP_CONT  = 3'b000,
    OP_JCC   = 3'b001,
    OP_CALL  = 3'b010,
    OP_RET   = 3'b011,
    OP_LDCNT = 3'b100,
    OP_LOOP  = 3'b101,
    OP_JMAP  = 3'b110,
    OP_JMP   = 3'b111
  } op_e;

  op_e                   op;
  logic [COND_SEL_W-1:0] csel;
  logic                  cpol;
  logic [CTRL_W-1:0]     ctrl;
  logic [ADDR_W-1:0]     target;
  logic                  cond_bit;
  logic                  cc;

  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic              err_q, err_d;
  logic              push;
  logic              full, empty;
  // Sized to the level width so the level can index it directly; entries past STACK_DEPTH are never written.
  logic [ADDR_W-1:0] stack_q [2**LVL_W];
`ifdef USEQ_LOOP_EN
  logic [ADDR_W-1:0] cnt_q, cnt_d;
`endif

  assign op     = op_e'(uword[UWORD_W-1 -: 3]);
  assign csel   = uword[CTRL_W+1 +: COND_SEL_W];
  assign cpol   = uword[CTRL_W];
  assign ctrl   = uword[CTRL_W-1:0];
  assign target = ctrl[ADDR_W-1:0];

  always_comb begin
    cond_bit = cond[0];
    if (int'(csel) < NUM_COND) cond_bit = cond[csel];
  end

  assign cc     = cond_bit ^ cpol;
  assign pc_inc = pc_q + ADDR_W'(1);
  assign full   = (lvl_q == LVL_W'(STACK_DEPTH));
  assign empty  = (lvl_q == '0);

  always_comb begin
    pc_d  = pc_q;
    lvl_d = lvl_q;
    err_d = err_q;
    push  = 1'b0;
`ifdef USEQ_LOOP_EN
    cnt_d = cnt_q;
`endif
    if (!hold) begin
      pc_d = pc_inc;
      case (op)
        OP_JCC: if (cc) pc_d = target;
        OP_CALL: begin
          if (cc) begin
            if (!full) begin
              push  = 1'b1;
              lvl_d = lvl_q + LVL_W'(1);
              pc_d  = target;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        OP_RET: begin
          if (cc) begin
            if (!empty) begin
              lvl_d = lvl_q - LVL_W'(1);
              pc_d  = stack_q[lvl_q - LVL_W'(1)];
            end else begin
              err_d = 1'b1;
            end
          end
        end
`ifdef USEQ_LOOP_EN
        OP_LDCNT: cnt_d = target;
        OP_LOOP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - ADDR_W'(1);
            pc_d  = target;
          end
        end
`endif
        OP_JMAP: pc_d = map_addr;
        OP_JMP:  pc_d = target;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q  <= '0;
      lvl_q <= '0;
      err_q <= 1'b0;
`ifdef USEQ_LOOP_EN
      cnt_q <= '0;
`endif
    end else begin
      pc_q  <= pc_d;
      lvl_q <= lvl_d;
      err_q <= err_d;
`ifdef USEQ_LOOP_EN
      cnt_q <= cnt_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push) stack_q[lvl_q] <= pc_inc;
  end

  assign uaddr       = pc_q;
  assign control_bus = hold ? '0 : ctrl;
  assign stack_level = lvl_q;
  assign stack_err   = err_q;

endmodule

// File: tb/tb_microprogram_sequencer.sv
// Directed bench for microprogram_sequencer with a behavioural microcode ROM and an expected-address queue.
module tb_microprogram_sequencer;
  localparam int AW  = 7;
  localparam int CW  = 17;
  localparam int NC  = 4;
  localparam int SD  = 2;
  localparam int CSW = 2;
  localparam int UW  = 3 + CSW + 1 + CW;
  localparam int SLW = 2;

  logic           clock = 1'b0;
  logic           reset;
  logic           hold;
  logic [NC-1:0]  cond;
  logic [AW-1:0]  map_addr;
  logic [UW-1:0]  uword;
  logic [AW-1:0]  uaddr;
  logic [CW-1:0]  control_bus;
  logic [SLW-1:0] stack_level;
  logic           stack_err;

  logic [UW-1:0] rom [2**AW];
  logic [AW-1:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  microprogram_sequencer #(
    .ADDR_W(AW), .CTRL_W(CW), .NUM_COND(NC), .STACK_DEPTH(SD)
  ) dut (
    .clock(clock), .reset(reset), .hold(hold), .cond(cond), .map_addr(map_addr),
    .uword(uword), .uaddr(uaddr), .control_bus(control_bus),
    .stack_level(stack_level), .stack_err(stack_err)
  );

  assign uword = rom[uaddr];

  always #5 clock = ~clock;

  function automatic logic [UW-1:0] mk(input logic [2:0] op, input logic [CSW-1:0] cs,
                                       input logic cp, input logic [CW-1:0] c);
    return {op, cs, cp, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [AW-1:0] e);
    logic [AW-1:0] x;
    logic [CW-1:0] ectl;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    x = exp_q.pop_front();
    ectl = rom[x][CW-1:0];
    if (hold) ectl = '0;
    chk("uaddr", 32'(uaddr), 32'(x));
    chk("control_bus", 32'(control_bus), 32'(ectl));
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) rom[i] = mk(3'b000, '0, 1'b0, CW'(i * 3 + 5));
    reset = 1'b1; hold = 1'b0; cond = '0; map_addr = '0;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("rst_uaddr", 32'(uaddr), 32'd0);
    chk("rst_ctrl", 32'(control_bus), 32'(rom[0][CW-1:0]));
    chk("rst_level", 32'(stack_level), 32'd0);
    chk("rst_err", 32'(stack_err), 32'd0);

    // straight-line CONT
    rom[3] = mk(3'b001, 2'd1, 1'b0, CW'(7'h40));
    cond = 4'b0010;
    step(7'd1); step(7'd2); step(7'd3);
    // JCC taken, not taken, inverted polarity
    rom[7'h41] = mk(3'b111, '0, 1'b0, CW'(7'h03));
    step(7'h40); step(7'h41);
    cond = 4'b0000;
    rom[4] = mk(3'b001, 2'd1, 1'b1, CW'(7'h40));
    step(7'h03); step(7'h04);
    step(7'h40);
    rom[7'h41] = mk(3'b111, '0, 1'b0, CW'(7'h04));
    step(7'h41); step(7'h04);
    cond = 4'b0010;
    step(7'h05);

    // CALL / RET
    cond = 4'b0000;
    rom[5]     = mk(3'b010, 2'd0, 1'b1, CW'(7'h20));
    rom[7'h20] = mk(3'b011, 2'd0, 1'b1, '0);
    step(7'h20);
    chk("call_level", 32'(stack_level), 32'd1);
    step(7'h06);
    chk("ret_level", 32'(stack_level), 32'd0);

    // nested CALLs overflow a 2-deep stack
    rom[6]     = mk(3'b010, 2'd0, 1'b1, CW'(7'h30));
    rom[7'h30] = mk(3'b010, 2'd0, 1'b1, CW'(7'h50));
    rom[7'h50] = mk(3'b010, 2'd0, 1'b1, CW'(7'h60));
    rom[7'h51] = mk(3'b011, 2'd0, 1'b1, '0);
    rom[7'h31] = mk(3'b011, 2'd0, 1'b1, '0);
    rom[7]     = mk(3'b011, 2'd0, 1'b1, '0);
    step(7'h30);
    chk("nest1_level", 32'(stack_level), 32'd1);
    step(7'h50);
    chk("nest2_level", 32'(stack_level), 32'd2);
    chk("nest2_err", 32'(stack_err), 32'd0);
    step(7'h51);
    chk("ovf_level", 32'(stack_level), 32'd2);
    chk("ovf_err", 32'(stack_err), 32'd1);
    step(7'h31);
    chk("pop1_level", 32'(stack_level), 32'd1);
    step(7'h07);
    chk("pop2_level", 32'(stack_level), 32'd0);
    step(7'h08);
    chk("unf_level", 32'(stack_level), 32'd0);

    // loop counter
    rom[8] = mk(3'b100, '0, 1'b0, CW'(3));
    rom[9] = mk(3'b101, '0, 1'b0, CW'(9));
    step(7'h09);
`ifdef USEQ_LOOP_EN
    step(7'h09); step(7'h09); step(7'h09);
`endif
    step(7'h0a);

    // dispatch and address wrap
    rom[10]    = mk(3'b110, '0, 1'b0, CW'(7'h11));
    rom[7'h71] = mk(3'b111, '0, 1'b0, CW'(7'h7f));
    map_addr = 7'h70;
    step(7'h70); step(7'h71); step(7'h7f); step(7'h00);

    // stall
    step(7'h01);
    hold = 1'b1;
    step(7'h01); step(7'h01); step(7'h01);
    chk("hold_level", 32'(stack_level), 32'd0);
    chk("hold_err", 32'(stack_err), 32'd1);
    hold = 1'b0;
    step(7'h02);

    // reset wins over hold
    hold = 1'b1; reset = 1'b1;
    step(7'h00);
    chk("rsthold_err", 32'(stack_err), 32'd0);
    chk("rsthold_level", 32'(stack_level), 32'd0);
    hold = 1'b0; reset = 1'b0;
    #1;
    chk("post_rst_ctrl", 32'(control_bus), 32'(rom[0][CW-1:0]));

    // RET on empty stack
    rom[0] = mk(3'b011, 2'd0, 1'b1, '0);
    step(7'h01);
    chk("ret_empty_err", 32'(stack_err), 32'd1);
    chk("ret_empty_level", 32'(stack_level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
